cdf_pipeline: RTL and testbench

- Second stage of the histogram equalizer. Runs after the histogram-count stage has filled scratchpad m2 with 256 tagged bin counts.
- Reads bins 0..255 of m2 in order, forms the running cumulative sum (CDF), and writes one CDF word per bin into scratchpad m3.
- Reports cdfMin (CDF value at the first non-empty bin) and cdfTotal (the final CDF value) for the downstream mapping stage.
- Uses the same start/done handshake and the same shared-bus tri-state convention as the counting stage.

---
 rtl/cdf_pipeline.sv | 122 ++++++++++++
 tb/tb_cdf_pipeline.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/cdf_pipeline.sv
// Histogram equalizer CDF stage: walks the 256 tagged bin counts in m2,
// writes the running cumulative sum per bin into m3, reports cdfMin/cdfTotal.
// Ports: start/done level handshake; m2 read port (1-cycle latency);
//   tri-stated m3 write port; cdfMin/cdfTotal valid while done=1.
// Latency: first m3 write 3 cycles after start is sampled, done 259 cycles after.
// Backpressure: none; one bin per cycle. Dropping start mid-frame aborts.
module cdf_pipeline #(
    parameter int          NUM_BINS  = 256,
    parameter logic [15:0] VALID_TAG = 16'hAAAA
) (
    input  logic         clock,
    input  logic         rst_n,
    input  logic         start,
    input  logic         inputBaseOffset,
    input  logic         outputBaseOffset,
    input  logic [127:0] m2ReadVal,
    output logic [15:0]  m2ReadAddr_out,
    output logic [15:0]  m3WriteAddr_out,
    output logic [127:0] m3WriteVal_out,
    output logic         m3WE_out,
    output logic [31:0]  cdfMin,
    output logic [31:0]  cdfTotal,
    output logic         done
);
    localparam logic [7:0] LAST_BIN = 8'(NUM_BINS - 1);

    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

    state_t        state, state_nxt;
    logic [7:0]    bin;
    logic [1:0]    drain_cnt;
    logic          rd_vld;      // m2ReadVal holds data for rd_bin this cycle
    logic [7:0]    rd_bin;
    logic [31:0]   sum;
    logic          found;
    logic          we;
    logic [15:0]   waddr;
    logic [127:0]  wval;
    logic [31:0]   count;
    logic [31:0]   sum_nxt;
    logic          accum;
    logic          unused_ok;

    assign unused_ok = ^m2ReadVal[127:32];

    // Untagged words are stale data from an earlier frame and count as empty.
    assign count   = (m2ReadVal[31:16] == VALID_TAG) ? {16'b0, m2ReadVal[15:0]} : 32'b0;
    assign sum_nxt = sum + count;
    // Gating on start discards the in-flight bin the moment a frame is aborted.
    assign accum   = rd_vld && start;

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (start) state_nxt = READ;
            READ:  if (!start) state_nxt = IDLE;
                   else if (bin == LAST_BIN) state_nxt = DRAIN;
            DRAIN: if (!start) state_nxt = IDLE;
                   else if (drain_cnt == 2'd1) state_nxt = DONE;
            DONE:  if (!start) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            bin       <= 8'd0;
            drain_cnt <= 2'd0;
            rd_vld    <= 1'b0;
            rd_bin    <= 8'd0;
            sum       <= 32'd0;
            found     <= 1'b0;
            cdfMin    <= 32'd0;
            cdfTotal  <= 32'd0;
            we        <= 1'b0;
            waddr     <= 16'd0;
            wval      <= 128'd0;
            done      <= 1'b0;
        end else begin
            done      <= (state_nxt == DONE);
            rd_vld    <= (state == READ) && start;
            rd_bin    <= bin;
            we        <= accum;
            drain_cnt <= (state == DRAIN) ? drain_cnt + 2'd1 : 2'd0;

            if (state == READ && start)
                bin <= bin + 8'd1;

            // Frame-level state clears on entry so back-to-back frames are independent.
            if (state == IDLE && start) begin
                bin      <= 8'd0;
                sum      <= 32'd0;
                found    <= 1'b0;
                cdfMin   <= 32'd0;
                cdfTotal <= 32'd0;
            end

            if (accum) begin
                sum   <= sum_nxt;
                waddr <= {7'b0, outputBaseOffset, rd_bin};
                wval  <= {96'b0, VALID_TAG, sum_nxt[15:0]};
                if (!found && count != 32'd0) begin
                    found  <= 1'b1;
                    cdfMin <= sum_nxt;
                end
                if (rd_bin == LAST_BIN)
                    cdfTotal <= sum_nxt;
            end
        end
    end

    // Shared buses: only drive while this stage owns them.
    assign m2ReadAddr_out  = start ? {7'b0, inputBaseOffset, bin} : 16'bz;
    assign m3WE_out        = we ? 1'b1 : 1'bz;
    assign m3WriteAddr_out = we ? waddr : 16'bz;
    assign m3WriteVal_out  = we ? wval : 128'bz;
endmodule

// File: tb/tb_cdf_pipeline.sv
module tb_cdf_pipeline;
    logic         clock = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         inputBaseOffset = 1'b0;
    logic         outputBaseOffset = 1'b0;
    logic [127:0] m2ReadVal = 128'd0;
    wire  [15:0]  m2ReadAddr_out;
    wire  [15:0]  m3WriteAddr_out;
    wire  [127:0] m3WriteVal_out;
    wire          m3WE_out;
    wire  [31:0]  cdfMin;
    wire  [31:0]  cdfTotal;
    wire          done;

    cdf_pipeline dut (
        .clock(clock), .rst_n(rst_n), .start(start),
        .inputBaseOffset(inputBaseOffset), .outputBaseOffset(outputBaseOffset),
        .m2ReadVal(m2ReadVal), .m2ReadAddr_out(m2ReadAddr_out),
        .m3WriteAddr_out(m3WriteAddr_out), .m3WriteVal_out(m3WriteVal_out),
        .m3WE_out(m3WE_out), .cdfMin(cdfMin), .cdfTotal(cdfTotal), .done(done)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [15:0]  a;
        logic [127:0] v;
    } wr_t;

    logic [31:0] mem [512];
    wr_t         exp_q [$];
    int          n_assert = 0;
    int          n_fail   = 0;
    int          writes   = 0;
    logic [15:0] last_addr = 16'd0;

    // m2 model: one-cycle read latency.
    always @(posedge clock)
        m2ReadVal <= {96'b0, mem[m2ReadAddr_out[8:0]]};

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: every m3 write is popped against the scoreboard.
    always @(negedge clock) begin
        if (m3WE_out === 1'b1) begin
            writes++;
            last_addr = m3WriteAddr_out;
            if (exp_q.size() == 0) begin
                n_assert++;
                n_fail++;
                $display("FAIL unexpected_write: addr %0h val %0h, expected no write",
                         m3WriteAddr_out, m3WriteVal_out);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("m3_write", {m3WriteAddr_out, m3WriteVal_out}, {e.a, e.v});
            end
        end
    end

    task automatic fill_all(input logic [31:0] w);
        for (int i = 0; i < 512; i++) mem[i] = w;
    endtask

    // Expected m3 contents: running sum of tagged counts from the selected bank.
    task automatic push_expected(input logic ibo, input logic obo);
        logic [31:0] s;
        logic [31:0] w;
        wr_t e;
        s = 32'd0;
        for (int k = 0; k < 256; k++) begin
            w = mem[{ibo, 8'(k)}];
            if (w[31:16] == 16'hAAAA) s = s + {16'b0, w[15:0]};
            e.a = {7'b0, obo, 8'(k)};
            e.v = {96'b0, 16'hAAAA, s[15:0]};
            exp_q.push_back(e);
        end
    endtask

    task automatic run_frame(input string nm, input logic [31:0] emin, input logic [31:0] etot);
        int n;
        int first_wr;
        int w0;
        bit seen;
        bit held;
        n = 0; first_wr = 0; seen = 0; held = 1;
        @(negedge clock);
        w0 = writes;
        start = 1'b1;
        while (n < 400 && !seen) begin
            @(posedge clock);
            n++;
            @(negedge clock);
            if (first_wr == 0 && m3WE_out === 1'b1) first_wr = n;
            if (done === 1'b1) seen = 1;
        end
        check({nm, "_done_cycle"}, n, 259);
        check({nm, "_first_write_cycle"}, first_wr, 3);
        check({nm, "_write_count"}, writes - w0, 256);
        check({nm, "_cdfMin"}, cdfMin, emin);
        check({nm, "_cdfTotal"}, cdfTotal, etot);
        // start held in DONE: no restart, done stays up.
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            if (done !== 1'b1) held = 0;
        end
        check({nm, "_done_held"}, held, 1'b1);
        start = 1'b0;
        @(negedge clock);
        check({nm, "_done_drop"}, done, 1'b0);
        check({nm, "_queue_empty"}, exp_q.size(), 0);
    endtask

    initial begin
        int w0;
        bit quiet;
        fill_all(32'h0);
        #1;
        check("reset_done", done, 1'b0);
        check("reset_cdfMin", cdfMin, 32'd0);
        check("reset_cdfTotal", cdfTotal, 32'd0);
        check("reset_we_off", m3WE_out === 1'b1, 1'b0);
        #20;
        @(negedge clock);
        rst_n = 1'b1;

        // All bins tagged with count 1.
        fill_all({16'hAAAA, 16'd1});
        inputBaseOffset = 0; outputBaseOffset = 0;
        push_expected(0, 0);
        run_frame("ones", 32'd1, 32'd256);

        // Sparse bins in bank 1; bank 0 holds decoy data.
        fill_all({16'hAAAA, 16'd3});
        for (int i = 256; i < 512; i++) mem[i] = {16'h0000, 16'hFFFF};
        mem[256 + 10]  = {16'hAAAA, 16'd5};
        mem[256 + 200] = {16'hAAAA, 16'd7};
        inputBaseOffset = 1; outputBaseOffset = 0;
        push_expected(1, 0);
        run_frame("sparse", 32'd5, 32'd12);

        // Nothing tagged.
        fill_all({16'h0000, 16'hFFFF});
        inputBaseOffset = 0; outputBaseOffset = 0;
        push_expected(0, 0);
        run_frame("empty", 32'd0, 32'd0);

        // Only the last bin, maximum count, upper m3 bank.
        fill_all({16'hAAAA, 16'd0});
        mem[255] = {16'hAAAA, 16'hFFFF};
        inputBaseOffset = 0; outputBaseOffset = 1;
        push_expected(0, 1);
        run_frame("last_bin", 32'd65535, 32'd65535);
        check("last_bin_addr", last_addr, 16'h01FF);

        // Abort by dropping start at cycle 100.
        fill_all({16'hAAAA, 16'd1});
        inputBaseOffset = 0; outputBaseOffset = 0;
        push_expected(0, 0);
        @(negedge clock);
        start = 1'b1;
        for (int n = 0; n < 100; n++) begin
            @(posedge clock);
            @(negedge clock);
        end
        start = 1'b0;
        w0 = writes;
        quiet = 1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            if (m3WE_out === 1'b1 && i > 0) quiet = 0;
            if (done === 1'b1) quiet = 0;
        end
        check("abort_extra_writes_le1", (writes - w0) <= 1, 1'b1);
        check("abort_quiet", quiet, 1'b1);
        exp_q.delete();
        push_expected(0, 0);
        run_frame("after_abort", 32'd1, 32'd256);

        // Reset pulse at cycle 50.
        inputBaseOffset = 1; outputBaseOffset = 0;
        push_expected(1, 0);
        @(negedge clock);
        start = 1'b1;
        for (int n = 0; n < 50; n++) begin
            @(posedge clock);
            @(negedge clock);
        end
        rst_n = 1'b0;
        #1;
        check("rst_we_off", m3WE_out === 1'b1, 1'b0);
        check("rst_cdfMin", cdfMin, 32'd0);
        check("rst_done", done, 1'b0);
        check("rst_read_addr", m2ReadAddr_out, 16'h0100);
        start = 1'b0;
        @(negedge clock);
        check("rst_held_we_off", m3WE_out === 1'b1, 1'b0);
        exp_q.delete();
        rst_n = 1'b1;
        push_expected(1, 0);
        run_frame("after_reset", 32'd1, 32'd256);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
